// File: rtl/dequant_page_if.sv
// Handshake bundle between the dequant page controller and its producer/consumer/port-B
// neighbours. master = the surrounding datapath, slave = the page controller.
interface dequant_page_if;
    // Level/pulse semantics: prod_start is honoured only in a cycle where prod_ready=1
    // (otherwise prod_err pulses); cons_ack is honoured only while cons_valid=1; prod_done
    // and cons_done are single-cycle pulses ending the owner's tenure of its page.
    logic       flush;
    logic       prod_start;
    logic       prod_ready;
    logic       prod_page;
    logic       prod_busy;
    logic       prod_done;
    logic       cons_valid;
    logic       cons_page;
    logic       cons_ack;
    logic       cons_done;
    logic       clr_we;
    logic [8:0] clr_addr;
    logic       prod_err;

    modport master (
        output flush, prod_start, prod_done, cons_ack, cons_done,
        input  prod_ready, prod_page, prod_busy, cons_valid, cons_page,
               clr_we, clr_addr, prod_err
    );

    modport slave (
        input  flush, prod_start, prod_done, cons_ack, cons_done,
        output prod_ready, prod_page, prod_busy, cons_valid, cons_page,
               clr_we, clr_addr, prod_err
    );
endinterface

// File: rtl/dequant_page_ctrl.sv
// Ping-pong page manager for the dequantizer result RAM: hands empty pages to the writer,
// full pages (in order) to the IDCT reader, and zero-fills released pages via port B.
module dequant_page_ctrl #(
    parameter int BLK_WORDS = 64
) (
    input  logic         clk,
    input  logic         srst,
    dequant_page_if.slave pif,
    output logic [5:0]   dbg_state    // {page1, page0}: EMPTY=0 FILL=1 FULL=2 READ=3 CLEAR=4
);
    localparam int IDX_W = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLK_WORDS - 1);

    typedef enum logic [2:0] {
        PG_EMPTY = 3'd0,
        PG_FILL  = 3'd1,
        PG_FULL  = 3'd2,
        PG_READ  = 3'd3,
        PG_CLEAR = 3'd4
    } pg_state_e;

    pg_state_e        st_q [2];
    pg_state_e        st_n [2];
    logic             wr_ptr_q, wr_ptr_n;
    logic             rd_ptr_q, rd_ptr_n;
    logic             busy_q, busy_n;
    logic             page_q, page_n;
    logic             err_q, err_n;
    logic             init_q, init_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    // Release-ordered queue of pages awaiting zero-fill; entry 0 is being cleared.
    logic             clrq_q [2];
    logic             clrq_n [2];
    logic [1:0]       cnt_q, cnt_n;

    logic any_read;
    logic prod_ready;
    logic cons_valid;
    logic clr_we;

    assign any_read   = (st_q[0] == PG_READ) || (st_q[1] == PG_READ);
    // init_q keeps the producer out until the post-reset zero-fill of both pages is over.
    assign prod_ready = init_q && !busy_q && (st_q[wr_ptr_q] == PG_EMPTY);
    assign cons_valid = (st_q[rd_ptr_q] == PG_FULL);
    // Port B belongs to the consumer while any page is READ; the clear simply stalls.
    assign clr_we     = (cnt_q != 2'd0) && !any_read;

    assign pif.prod_ready = prod_ready;
    assign pif.prod_page  = page_q;
    assign pif.prod_busy  = busy_q;
    assign pif.cons_valid = cons_valid;
    assign pif.cons_page  = rd_ptr_q;
    assign pif.clr_we     = clr_we;
    assign pif.clr_addr   = (cnt_q != 2'd0) ? {2'b00, clrq_q[0], 6'(idx_q)} : 9'd0;
    assign pif.prod_err   = err_q;
    assign dbg_state      = {st_q[1], st_q[0]};

    always_comb begin
        st_n     = st_q;
        clrq_n   = clrq_q;
        cnt_n    = cnt_q;
        idx_n    = idx_q;
        wr_ptr_n = wr_ptr_q;
        rd_ptr_n = rd_ptr_q;
        busy_n   = busy_q;
        page_n   = page_q;
        err_n    = 1'b0;
        init_n   = init_q;

        if (pif.flush) begin
            // Rebuild the clear queue from scratch: the page the reader owns goes first.
            cnt_n = 2'd0;
            if (st_q[rd_ptr_q] != PG_EMPTY) begin
                st_n[rd_ptr_q] = PG_CLEAR;
                clrq_n[0]      = rd_ptr_q;
                cnt_n          = 2'd1;
            end
            if (st_q[~rd_ptr_q] != PG_EMPTY) begin
                st_n[~rd_ptr_q]    = PG_CLEAR;
                clrq_n[cnt_n[0]]   = ~rd_ptr_q;
                cnt_n              = cnt_n + 2'd1;
            end
            wr_ptr_n = 1'b0;
            rd_ptr_n = 1'b0;
            busy_n   = 1'b0;
            idx_n    = '0;
        end else begin
            if (clr_we) begin
                if (idx_q == IDX_LAST) begin
                    st_n[clrq_q[0]] = PG_EMPTY;
                    clrq_n[0]       = clrq_q[1];
                    cnt_n           = cnt_q - 2'd1;
                    idx_n           = '0;
                end else begin
                    idx_n = idx_q + 1'b1;
                end
            end

            if (pif.prod_start) begin
                if (prod_ready) begin
                    st_n[wr_ptr_q] = PG_FILL;
                    busy_n         = 1'b1;
                    page_n         = wr_ptr_q;
                end else begin
                    err_n = 1'b1;
                end
            end

            if (pif.prod_done && busy_q && (st_q[page_q] == PG_FILL)) begin
                st_n[page_q] = PG_FULL;
                wr_ptr_n     = ~wr_ptr_q;
                busy_n       = 1'b0;
            end

            if (pif.cons_ack && cons_valid) begin
                st_n[rd_ptr_q] = PG_READ;
            end

            // Push after a possible pop above so a same-cycle finish/release keeps order.
            if (pif.cons_done && (st_q[rd_ptr_q] == PG_READ)) begin
                st_n[rd_ptr_q]   = PG_CLEAR;
                clrq_n[cnt_n[0]] = rd_ptr_q;
                cnt_n            = cnt_n + 2'd1;
                rd_ptr_n         = ~rd_ptr_q;
            end
        end

        if (cnt_n == 2'd0) begin
            init_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            st_q[0]   <= PG_CLEAR;
            st_q[1]   <= PG_CLEAR;
            clrq_q[0] <= 1'b0;
            clrq_q[1] <= 1'b1;
            cnt_q     <= 2'd2;
            idx_q     <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            busy_q    <= 1'b0;
            page_q    <= 1'b0;
            err_q     <= 1'b0;
            init_q    <= 1'b0;
        end else begin
            st_q      <= st_n;
            clrq_q    <= clrq_n;
            cnt_q     <= cnt_n;
            idx_q     <= idx_n;
            wr_ptr_q  <= wr_ptr_n;
            rd_ptr_q  <= rd_ptr_n;
            busy_q    <= busy_n;
            page_q    <= page_n;
            err_q     <= err_n;
            init_q    <= init_n;
        end
    end
endmodule

// File: tb/tb_dequant_page_ctrl.sv
// Bench for dequant_page_ctrl: a RAM model carries sparse blocks through the page
// ping-pong; the reader compares each page it takes against the block queued by the writer.
module tb_dequant_page_ctrl;
  localparam int BW = 64;
  localparam int W  = BW * 12;
  localparam logic [5:0] DBG_IDLE     = 6'b000_000;
  localparam logic [5:0] DBG_FULL2    = 6'b010_010;
  localparam logic [5:0] DBG_CLEAR2   = 6'b100_100;

  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic [5:0] dbg_state;

  dequant_page_if pif();

  dequant_page_ctrl #(.BLK_WORDS(BW)) dut (
    .clk       (clk),
    .srst      (srst),
    .pif       (pif),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Dual-port result RAM: port A written by the bench producer, port B by the zero-fill.
  logic [11:0] mem [512];
  logic        pa_we   = 1'b0;
  logic [8:0]  pa_addr = 9'd0;
  logic [11:0] pa_din  = 12'd0;

  always @(posedge clk) begin
    if (pa_we) mem[pa_addr] <= pa_din;
    if (pif.clr_we) mem[pif.clr_addr] <= 12'd0;
  end

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  bit exp_wr_page = 1'b0;
  bit exp_rd_page = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expect n consecutive zero-fill writes to page starting at index start.
  task automatic check_clear_run(input string name, input bit page, input int start, input int n);
    int bad = 0;
    logic [8:0] first_got = 9'd0;
    logic [8:0] first_exp = 9'd0;
    for (int k = 0; k < n; k++) begin
      logic [8:0] ea;
      ea = {2'b00, page, 6'(start + k)};
      if (!(pif.clr_we === 1'b1 && pif.clr_addr === ea)) begin
        if (bad == 0) begin
          first_got = pif.clr_we ? pif.clr_addr : 9'h1FF;
          first_exp = ea;
        end
        bad++;
      end
      tick();
    end
    chk(name, 32'(first_got), 32'(first_exp));
  endtask

  // Release srst and expect 128 ordered zero-fill writes, then prod_ready.
  task automatic reset_check(input string tag);
    int bad = 0;
    srst = 1'b0;
    exp_q.delete();
    exp_wr_page = 1'b0;
    exp_rd_page = 1'b0;
    chk({tag, "_cons_valid"}, 32'(pif.cons_valid), 0);
    chk({tag, "_prod_busy"}, 32'(pif.prod_busy), 0);
    chk({tag, "_prod_err"}, 32'(pif.prod_err), 0);
    for (int i = 0; i < 2 * BW; i++) begin
      if (!(pif.clr_we === 1'b1 && pif.clr_addr === 9'(i) && pif.prod_ready === 1'b0)) bad++;
      tick();
    end
    chk({tag, "_clear_seq_bad_cycles"}, 32'(bad), 0);
    chk({tag, "_prod_ready_after"}, 32'(pif.prod_ready), 1);
    chk({tag, "_clr_we_idle"}, 32'(pif.clr_we), 0);
    chk({tag, "_clr_addr_idle"}, 32'(pif.clr_addr), 0);
  endtask

  task automatic prod_begin(output bit ok);
    int t = 0;
    while (pif.prod_ready !== 1'b1 && t < 3000) begin
      tick();
      t++;
    end
    ok = (pif.prod_ready === 1'b1);
    if (!ok) begin
      chk("prod_ready_timeout", 32'(pif.prod_ready), 1);
      return;
    end
    pif.prod_start = 1'b1;
    tick();
    pif.prod_start = 1'b0;
    chk("prod_busy", 32'(pif.prod_busy), 1);
    chk("prod_page", 32'(pif.prod_page), 32'(exp_wr_page));
  endtask

  task automatic prod_fill(input int nwr, output logic [W-1:0] blk);
    blk = '0;
    for (int i = 0; i < nwr; i++) begin
      logic [5:0]  ix;
      logic [11:0] v;
      ix = 6'($urandom_range(0, 63));
      v  = 12'($urandom_range(1, 4095));
      pa_we   = 1'b1;
      pa_addr = {2'b00, pif.prod_page, ix};
      pa_din  = v;
      blk[ix * 12 +: 12] = v;
      tick();
    end
    pa_we = 1'b0;
  endtask

  task automatic prod_finish(input logic [W-1:0] blk);
    pif.prod_done = 1'b1;
    exp_q.push_back(blk);
    tick();
    pif.prod_done = 1'b0;
    exp_wr_page = ~exp_wr_page;
  endtask

  task automatic produce(input int nwr);
    bit ok;
    logic [W-1:0] blk;
    prod_begin(ok);
    if (ok) begin
      prod_fill(nwr, blk);
      prod_finish(blk);
    end
  endtask

  task automatic cons_ack_page(output bit ok);
    int t = 0;
    while (pif.cons_valid !== 1'b1 && t < 3000) begin
      tick();
      t++;
    end
    ok = (pif.cons_valid === 1'b1);
    if (!ok) begin
      chk("cons_valid_timeout", 32'(pif.cons_valid), 1);
      return;
    end
    chk("cons_page", 32'(pif.cons_page), 32'(exp_rd_page));
    pif.cons_ack = 1'b1;
    tick();
    pif.cons_ack = 1'b0;
  endtask

  // Read the owned page word by word, compare with the oldest queued block, release it.
  task automatic cons_read_done();
    logic [W-1:0] got;
    logic [W-1:0] exp;
    int conflicts = 0;
    for (int i = 0; i < BW; i++) begin
      got[i * 12 +: 12] = mem[{2'b00, pif.cons_page, 6'(i)}];
      if (pif.clr_we !== 1'b0) conflicts++;
      tick();
    end
    chk("port_b_busy_during_read", 32'(conflicts), 0);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL block_data: page offered with no block outstanding at %0t", $time);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        int w = 0;
        n_errors++;
        for (int i = BW - 1; i >= 0; i--) if (got[i * 12 +: 12] !== exp[i * 12 +: 12]) w = i;
        $display("FAIL block_data: word %0d got 0x%0h expected 0x%0h at %0t",
                 w, got[w * 12 +: 12], exp[w * 12 +: 12], $time);
      end
    end
    pif.cons_done = 1'b1;
    tick();
    pif.cons_done = 1'b0;
    exp_rd_page = ~exp_rd_page;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (dbg_state !== DBG_IDLE && t < 3000) begin
      tick();
      t++;
    end
    chk(name, 32'(dbg_state), 32'(DBG_IDLE));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit pg_x;
    bit pg_y;
    logic [W-1:0] blk;

    pif.flush = 1'b0;
    pif.prod_start = 1'b0;
    pif.prod_done = 1'b0;
    pif.cons_ack = 1'b0;
    pif.cons_done = 1'b0;
    srst = 1'b1;

    // Garbage in both pages while held in reset; the init clear must remove it.
    tick();
    for (int i = 0; i < 2 * BW; i++) begin
      pa_we   = 1'b1;
      pa_addr = 9'(i);
      pa_din  = 12'($urandom_range(1, 4095));
      tick();
    end
    pa_we = 1'b0;
    tick();
    reset_check("t1_reset");

    // Single block through page 0 with exact clear timing.
    prod_begin(ok);
    prod_fill(5, blk);
    pif.prod_done = 1'b1;
    exp_q.push_back(blk);
    tick();
    pif.prod_done = 1'b0;
    exp_wr_page = ~exp_wr_page;
    chk("t2_cons_valid_next", 32'(pif.cons_valid), 1);
    chk("t2_cons_page", 32'(pif.cons_page), 0);
    chk("t2_prod_busy_low", 32'(pif.prod_busy), 0);
    cons_ack_page(ok);
    cons_read_done();
    check_clear_run("t2_clear_page0", 1'b0, 0, BW);
    chk("t2_page0_empty", 32'(dbg_state[2:0]), 0);
    chk("t2_clr_we_done", 32'(pif.clr_we), 0);

    // Both pages full: producer refused, error pulse, no state change.
    produce(7);
    tick();
    produce(3);
    chk("t3_prod_ready_low", 32'(pif.prod_ready), 0);
    chk("t3_both_full", 32'(dbg_state), 32'(DBG_FULL2));
    pif.prod_start = 1'b1;
    tick();
    pif.prod_start = 1'b0;
    chk("t3_prod_err", 32'(pif.prod_err), 1);
    chk("t3_state_kept", 32'(dbg_state), 32'(DBG_FULL2));
    chk("t3_prod_busy", 32'(pif.prod_busy), 0);
    tick();
    chk("t3_prod_err_pulse", 32'(pif.prod_err), 0);
    cons_ack_page(ok);
    cons_read_done();
    cons_ack_page(ok);
    cons_read_done();
    wait_idle("t3_idle");

    // Reader takes the other page while a clear is at index 20: clear pauses and resumes.
    pg_x = exp_rd_page;
    pg_y = ~exp_rd_page;
    produce(9);
    produce(4);
    cons_ack_page(ok);
    cons_read_done();
    check_clear_run("t4_clear_first20", pg_x, 0, 20);
    chk("t4_at_idx20", 32'(pif.clr_we ? pif.clr_addr : 9'h1FF), 32'({2'b00, pg_x, 6'd20}));
    cons_ack_page(ok);
    cons_read_done();
    check_clear_run("t4_clear_resume", pg_x, 21, BW - 21);
    check_clear_run("t4_clear_second", pg_y, 0, BW);
    chk("t4_clr_we_done", 32'(pif.clr_we), 0);

    // srst while page 1 is at clear index 30.
    srst = 1'b1;
    tick();
    srst = 1'b0;
    repeat (BW + 30) tick();
    chk("t6_mid_clear_addr", 32'(pif.clr_addr), 32'(9'h05E));
    srst = 1'b1;
    tick();
    tick();
    reset_check("t6_reset");

    // Flush with page 0 in READ and page 1 in FILL.
    produce(6);
    cons_ack_page(ok);
    prod_begin(ok);
    prod_fill(3, blk);
    pif.flush = 1'b1;
    tick();
    pif.flush = 1'b0;
    chk("t5_prod_busy", 32'(pif.prod_busy), 0);
    chk("t5_cons_valid", 32'(pif.cons_valid), 0);
    chk("t5_both_clear", 32'(dbg_state), 32'(DBG_CLEAR2));
    check_clear_run("t5_clear_page0", 1'b0, 0, BW);
    check_clear_run("t5_clear_page1", 1'b1, 0, BW);
    chk("t5_idle", 32'(dbg_state), 32'(DBG_IDLE));
    exp_q.delete();
    exp_wr_page = 1'b0;
    exp_rd_page = 1'b0;

    // Randomized traffic: independent producer and reader.
    fork
      begin
        for (int b = 0; b < 40; b++) begin
          bit pok;
          logic [W-1:0] pblk;
          repeat ($urandom_range(0, 6)) tick();
          prod_begin(pok);
          if (!pok) break;
          prod_fill($urandom_range(0, 16), pblk);
          prod_finish(pblk);
        end
      end
      begin
        for (int b = 0; b < 40; b++) begin
          bit cok;
          repeat ($urandom_range(0, 4)) tick();
          cons_ack_page(cok);
          if (!cok) break;
          cons_read_done();
        end
      end
    join
    wait_idle("rand_idle");
    chk("rand_queue_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
